// File: rtl/neuron_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// neuron_sequencer_pkg
// Shared definitions for the neuron sequencer slice:
//   - seq_state_t : FSM state encoding (3 bits)
//   - DEFAULT_NUM_WORDS / DEFAULT_ADDR_DEPTH : default image geometry
// ---------------------------------------------------------------------------
package neuron_sequencer_pkg;

  localparam int DEFAULT_NUM_WORDS  = 4096;
  localparam int DEFAULT_ADDR_DEPTH = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    RESULT  = 3'd3,
    CAPTURE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/neuron_sequencer_seq_valid_delay.sv
// ---------------------------------------------------------------------------
// seq_valid_delay
// RD_LATENCY-deep shift register that turns the ROM read strobe into the
// calculator enable, so enable lines up with the ROM data it qualifies.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high clear of every stage
//   in_valid  : read strobe entering the line
//   out_valid : strobe leaving the line (calculator enable)
//   empty     : no read is queued behind the output stage, i.e. whatever
//               out_valid shows now is the last enable still in flight
// ---------------------------------------------------------------------------
module seq_valid_delay #(
  parameter int RD_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);

  logic [RD_LATENCY-1:0] stages;

  // Shift the strobe one stage per cycle; stage 0 takes the new strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages[0] <= in_valid;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign out_valid = stages[RD_LATENCY-1];

  // Only the stages behind the output matter: once they are clear, the
  // enable currently being driven is the final one.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      if (stages[i]) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
// Control stage in front of the neuron calculator. A start pulse walks the
// pixel/weight ROMs over addresses 0..NUM_WORDS-1, forwards the read data
// with a latency-aligned enable, pulses get_result once, captures the
// calculator decision and signals done.
// Optional build macro: SEQ_PAUSE_EN (pause input freezes address issue).
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   start              : one-cycle run request, honoured only when idle
//   pause              : hold address issue in RUN (SEQ_PAUSE_EN only)
//   rd_addr, rd_en     : shared ROM address and read strobe
//   pix_rdata, w_rdata : ROM read data, valid RD_LATENCY cycles after rd_en
//   x_out, w_out       : pass-through of ROM data to the calculator
//   enable             : calculator enable (rd_en delayed RD_LATENCY)
//   get_result         : one-cycle pulse asking the calculator for out1
//   neuron_out         : calculator decision
//   busy               : run in progress
//   done, result       : one-cycle done pulse and held decision (1 = cat)
// ---------------------------------------------------------------------------
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = 24,
  parameter int Addr_Depth       = DEFAULT_ADDR_DEPTH,
  parameter int Weight_Percision = 5,
  parameter int NUM_WORDS        = DEFAULT_NUM_WORDS,
  parameter int RD_LATENCY       = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  output logic [Addr_Depth-1:0]         rd_addr,
  output logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         pix_rdata,
  input  logic [3*Weight_Percision-1:0] w_rdata,
  output logic [DATA_WIDTH-1:0]         x_out,
  output logic [3*Weight_Percision-1:0] w_out,
  output logic                          enable,
  output logic                          get_result,
  input  logic                          neuron_out,
  output logic                          busy,
  output logic                          done,
  output logic                          result
);

  localparam logic [Addr_Depth-1:0] LAST_ADDR = Addr_Depth'(NUM_WORDS - 1);

  seq_state_t            state;
  seq_state_t            state_next;
  logic [Addr_Depth-1:0] addr;
  logic                  hold;
  logic                  issue;
  logic                  last_issue;
  logic                  drain_empty;

`ifdef SEQ_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold         = 1'b0;
`endif

  // A read goes out every RUN cycle unless issue is held; the read of the
  // final address is what ends the RUN phase.
  assign issue      = (state == RUN) && !hold;
  assign last_issue = issue && (addr == LAST_ADDR);

  assign rd_en      = issue;
  assign rd_addr    = addr;
  assign x_out      = pix_rdata;
  assign w_out      = w_rdata;
  assign get_result = (state == RESULT);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DRAIN waits until the enable being driven is the last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = RUN;
      RUN:     if (last_issue)  state_next = DRAIN;
      DRAIN:   if (drain_empty) state_next = RESULT;
      RESULT:                   state_next = CAPTURE;
      CAPTURE:                  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Address counter: zeroed while idle, advances only on an issued read and
  // stops on the last address so it never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= '0;
    end else if (state == IDLE) begin
      addr <= '0;
    end else if (issue && !last_issue) begin
      addr <= addr + 1'b1;
    end
  end

  // The decision is taken at the end of CAPTURE and announced with done in
  // the following cycle; result then holds until the next capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      done   <= 1'b0;
      result <= 1'b0;
    end else begin
      done <= (state == CAPTURE);
      if (state == CAPTURE) begin
        result <= neuron_out;
      end
    end
  end

  seq_valid_delay #(
    .RD_LATENCY(RD_LATENCY)
  ) u_valid_delay (
    .clock    (clock),
    .reset    (reset),
    .in_valid (rd_en),
    .out_valid(enable),
    .empty    (drain_empty)
  );

endmodule

// File: tb/tb_neuron_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_sequencer
// Three sequencer instances: A (8 words, latency 1), B (8 words, latency 3)
// and C (1 word, latency 1), each fed by a small address-pipelined ROM model.
// Cycle numbering: cycle 0 is the cycle start is driven; outputs for cycle c
// are sampled just after the falling edge inside that cycle.
// ---------------------------------------------------------------------------
module tb_neuron_sequencer;

  logic clock;
  logic reset;

  int checks;
  int errors;

  // Instance A
  logic        start_a, pause_a, neuron_a;
  logic [11:0] rd_addr_a, ra1;
  logic        rd_en_a, en_a, gr_a, busy_a, done_a, result_a;
  logic [23:0] pix_a, x_a;
  logic [14:0] w_a, wo_a;

  // Instance B
  logic        start_b;
  logic [11:0] rd_addr_b, rb1, rb2, rb3;
  logic        rd_en_b, en_b, gr_b, busy_b, done_b, result_b;
  logic [23:0] pix_b, x_b;
  logic [14:0] w_b, wo_b;

  // Instance C
  logic        start_c;
  logic [11:0] rd_addr_c;
  logic        rd_en_c, en_c, gr_c, busy_c, done_c, result_c;
  logic [23:0] x_c_unused;
  logic [14:0] wo_c_unused;

  neuron_sequencer #(.NUM_WORDS(8), .RD_LATENCY(1)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .pause(pause_a),
    .rd_addr(rd_addr_a), .rd_en(rd_en_a), .pix_rdata(pix_a), .w_rdata(w_a),
    .x_out(x_a), .w_out(wo_a), .enable(en_a), .get_result(gr_a),
    .neuron_out(neuron_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  neuron_sequencer #(.NUM_WORDS(8), .RD_LATENCY(3)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .pause(1'b0),
    .rd_addr(rd_addr_b), .rd_en(rd_en_b), .pix_rdata(pix_b), .w_rdata(w_b),
    .x_out(x_b), .w_out(wo_b), .enable(en_b), .get_result(gr_b),
    .neuron_out(1'b0), .busy(busy_b), .done(done_b), .result(result_b)
  );

  neuron_sequencer #(.NUM_WORDS(1), .RD_LATENCY(1)) u_c (
    .clock(clock), .reset(reset), .start(start_c), .pause(1'b0),
    .rd_addr(rd_addr_c), .rd_en(rd_en_c), .pix_rdata(24'h123456), .w_rdata(15'h1234),
    .x_out(x_c_unused), .w_out(wo_c_unused), .enable(en_c), .get_result(gr_c),
    .neuron_out(1'b1), .busy(busy_c), .done(done_c), .result(result_c)
  );

  // ROM models: data encodes the address it was read from.
  always @(posedge clock) begin
    ra1 <= rd_addr_a;
    rb1 <= rd_addr_b;
    rb2 <= rb1;
    rb3 <= rb2;
  end
  assign pix_a = {12'hABC, ra1};
  assign w_a   = {3'b101, ra1};
  assign pix_b = {12'hABC, rb3};
  assign w_b   = {3'b101, rb3};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic test_reset();
    reset = 1'b1;
    start_a = 1'b0; pause_a = 1'b0; neuron_a = 1'b0;
    start_b = 1'b0; start_c = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({rd_en_a, en_a, gr_a, busy_a, done_a, result_a} !== 6'b0 || rd_addr_a !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_a: got ctrl=%b addr=%0d, expected ctrl=000000 addr=0",
               {rd_en_a, en_a, gr_a, busy_a, done_a, result_a}, rd_addr_a);
    end
    checks++;
    if ({rd_en_b, en_b, busy_b, done_b, rd_en_c, en_c, busy_c, done_c} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_bc: got %b expected 00000000",
               {rd_en_b, en_b, busy_b, done_b, rd_en_c, en_c, busy_c, done_c});
    end
    reset = 1'b0;
  endtask

  // N=8, L=1: rd_en 1..8, enable 2..9, get_result 10, done 12, busy 1..11.
  // neuron_out is high only in the CAPTURE cycle (11).
  task automatic test_timing_l1();
    logic [4:0] exp_ctrl;
    @(negedge clock); start_a = 1'b1; #1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      start_a  = 1'b0;
      neuron_a = (c == 11);
      #1;
      exp_ctrl = {(c >= 1 && c <= 8), (c >= 2 && c <= 9), (c == 10), (c == 12), (c >= 1 && c <= 11)};
      checks++;
      if ({rd_en_a, en_a, gr_a, done_a, busy_a} !== exp_ctrl) begin
        errors++;
        $display("[TB] FAIL l1_ctrl cycle %0d: rd_en/enable/get_result/done/busy got %b expected %b",
                 c, {rd_en_a, en_a, gr_a, done_a, busy_a}, exp_ctrl);
      end
      if (exp_ctrl[4]) begin
        checks++;
        if (rd_addr_a !== 12'(c - 1)) begin
          errors++;
          $display("[TB] FAIL l1_addr cycle %0d: got %0d expected %0d", c, rd_addr_a, c - 1);
        end
      end
      if (exp_ctrl[3]) begin
        checks++;
        if (x_a !== {12'hABC, 12'(c - 2)} || wo_a !== {3'b101, 12'(c - 2)}) begin
          errors++;
          $display("[TB] FAIL l1_data cycle %0d: got x=%h w=%h expected x=%h", c, x_a, wo_a,
                   {12'hABC, 12'(c - 2)});
        end
      end
      if (c == 12 || c == 14) begin
        checks++;
        if (result_a !== 1'b1) begin
          errors++;
          $display("[TB] FAIL l1_result cycle %0d: got %b expected 1", c, result_a);
        end
      end
    end
    neuron_a = 1'b0;
  endtask

  // Second run: neuron_out high everywhere except CAPTURE, so result must
  // fall to 0 only at done, and hold 1 from the previous run until then.
  task automatic test_result_hold();
    @(negedge clock); start_a = 1'b1; #1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      start_a  = 1'b0;
      neuron_a = (c != 11);
      #1;
      if (c == 5 || c == 11) begin
        checks++;
        if (result_a !== 1'b1) begin
          errors++;
          $display("[TB] FAIL hold_prev cycle %0d: got %b expected 1", c, result_a);
        end
      end
      if (c == 12 || c == 14) begin
        checks++;
        if ({done_a, result_a} !== {(c == 12), 1'b0}) begin
          errors++;
          $display("[TB] FAIL hold_new cycle %0d: done/result got %b expected %b",
                   c, {done_a, result_a}, {(c == 12), 1'b0});
        end
      end
    end
    neuron_a = 1'b0;
  endtask

  // N=8, L=3: enable 4..11, get_result 12, done 14, data in address order.
  task automatic test_latency3();
    int k;
    logic [2:0] exp_ctrl;
    k = 0;
    @(negedge clock); start_b = 1'b1; #1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock); start_b = 1'b0; #1;
      exp_ctrl = {(c >= 4 && c <= 11), (c == 12), (c == 14)};
      checks++;
      if ({en_b, gr_b, done_b} !== exp_ctrl) begin
        errors++;
        $display("[TB] FAIL l3_ctrl cycle %0d: enable/get_result/done got %b expected %b",
                 c, {en_b, gr_b, done_b}, exp_ctrl);
      end
      if (en_b === 1'b1) begin
        checks++;
        if (x_b !== {12'hABC, 12'(k)} || wo_b !== {3'b101, 12'(k)}) begin
          errors++;
          $display("[TB] FAIL l3_data beat %0d: got x=%h w=%h expected x=%h w=%h",
                   k, x_b, wo_b, {12'hABC, 12'(k)}, {3'b101, 12'(k)});
        end
        k++;
      end
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("[TB] FAIL l3_beats: got %0d expected 8", k);
    end
  endtask

  // start re-pulsed in cycle 5 is ignored: one done, at cycle 12.
  task automatic test_start_ignored();
    int dones;
    int done_cycle;
    dones = 0; done_cycle = -1;
    @(negedge clock); start_a = 1'b1; #1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock); start_a = (c == 5); #1;
      if (done_a === 1'b1) begin
        dones++;
        done_cycle = c;
      end
      if (c == 6) begin
        checks++;
        if (rd_addr_a !== 12'd5 || busy_a !== 1'b1) begin
          errors++;
          $display("[TB] FAIL restart_addr cycle 6: got addr=%0d busy=%b expected 5 1", rd_addr_a, busy_a);
        end
      end
    end
    checks++;
    if (dones != 1 || done_cycle != 12) begin
      errors++;
      $display("[TB] FAIL restart_done: got %0d dones last at %0d expected 1 at 12", dones, done_cycle);
    end
  endtask

  // Reset at cycle 5, reset+start at cycle 6, fresh start at cycle 7.
  task automatic test_reset_midrun();
    @(negedge clock); start_a = 1'b1; #1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clock);
      start_a = (c == 6 || c == 7);
      reset   = (c == 5 || c == 6);
      #1;
      if (c == 6 || c == 7) begin
        checks++;
        if ({rd_en_a, en_a, gr_a, busy_a, done_a, result_a} !== 6'b0 || rd_addr_a !== 12'd0) begin
          errors++;
          $display("[TB] FAIL midreset cycle %0d: got ctrl=%b addr=%0d expected 000000 0",
                   c, {rd_en_a, en_a, gr_a, busy_a, done_a, result_a}, rd_addr_a);
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (rd_en_a !== 1'b1 || rd_addr_a !== 12'(c - 8)) begin
          errors++;
          $display("[TB] FAIL fresh_start cycle %0d: got rd_en=%b addr=%0d expected 1 %0d",
                   c, rd_en_a, rd_addr_a, c - 8);
        end
      end
      if (c == 19) begin
        checks++;
        if (done_a !== 1'b1) begin
          errors++;
          $display("[TB] FAIL fresh_done cycle 19: got %b expected 1", done_a);
        end
      end
    end
    reset = 1'b0; start_a = 1'b0;
  endtask

  // N=1, L=1: rd_en 1 (addr 0), enable 2, get_result 3, done 5, busy 1..4.
  task automatic test_single_word();
    logic [4:0] exp_ctrl;
    @(negedge clock); start_c = 1'b1; #1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock); start_c = 1'b0; #1;
      exp_ctrl = {(c == 1), (c == 2), (c == 3), (c == 5), (c >= 1 && c <= 4)};
      checks++;
      if ({rd_en_c, en_c, gr_c, done_c, busy_c} !== exp_ctrl || rd_addr_c !== 12'd0) begin
        errors++;
        $display("[TB] FAIL single cycle %0d: rd_en/enable/get_result/done/busy got %b addr=%0d expected %b addr=0",
                 c, {rd_en_c, en_c, gr_c, done_c, busy_c}, rd_addr_c, exp_ctrl);
      end
      if (c == 5) begin
        checks++;
        if (result_c !== 1'b1) begin
          errors++;
          $display("[TB] FAIL single_result: got %b expected 1", result_c);
        end
      end
    end
  endtask

  // pause in cycles 3..4 of an N=8, L=1 run.
  task automatic test_pause();
    int reads [8];
    int done_cycle;
    int exp_done;
    logic exp_rd, exp_en;
    foreach (reads[i]) reads[i] = 0;
    done_cycle = -1;
`ifdef SEQ_PAUSE_EN
    exp_done = 14;
`else
    exp_done = 12;
`endif
    @(negedge clock); start_a = 1'b1; #1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      pause_a = (c == 3 || c == 4);
      #1;
`ifdef SEQ_PAUSE_EN
      exp_rd = (c >= 1 && c <= 2) || (c >= 5 && c <= 10);
      exp_en = (c >= 2 && c <= 3) || (c >= 6 && c <= 11);
`else
      exp_rd = (c >= 1 && c <= 8);
      exp_en = (c >= 2 && c <= 9);
`endif
      checks++;
      if ({rd_en_a, en_a} !== {exp_rd, exp_en} || (en_a & gr_a) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_ctrl cycle %0d: rd_en/enable/get_result got %b expected %b%b0",
                 c, {rd_en_a, en_a, gr_a}, exp_rd, exp_en);
      end
      if (rd_en_a === 1'b1) begin
        if (rd_addr_a < 12'd8) reads[rd_addr_a] = reads[rd_addr_a] + 1;
      end
      if (done_a === 1'b1) done_cycle = c;
    end
    pause_a = 1'b0;
    checks++;
    if (done_cycle != exp_done) begin
      errors++;
      $display("[TB] FAIL pause_done: got cycle %0d expected %0d", done_cycle, exp_done);
    end
    foreach (reads[i]) begin
      checks++;
      if (reads[i] != 1) begin
        errors++;
        $display("[TB] FAIL pause_reads addr %0d: got %0d reads expected 1", i, reads[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_timing_l1();
    test_result_hold();
    test_latency3();
    test_start_ignored();
    test_reset_midrun();
    test_single_word();
    test_pause();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
